// File: rtl/bn_pkg.sv
// bn_pkg: shared definitions for the BN output path.
//   DATA_WIDTH  - default FP16 lane width
//   FP16_*      - handy FP16 bit patterns
//   state_e     - occupancy of the serializer's two-deep vector buffer
package bn_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // EMPTY: nothing held; ONE: act_reg valid; TWO: act_reg and pend_reg valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/bn_vec_serializer_if.sv
// bn_vec_serializer_if: packed-vector input bus plus per-element output stream.
//   in_vec/in_valid/in_ready          - packed vector handshake (upstream -> serializer)
//   elem_data/elem_valid/elem_ready   - element stream handshake (serializer -> downstream)
//   elem_chan/elem_ch_last/elem_last  - element tags
// master: the surrounding environment (drives vectors, consumes elements)
// slave : the serializer
interface bn_vec_serializer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int size       = 8,
    parameter int CW         = 1
);
    logic [DATA_WIDTH*size-1:0] in_vec;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH-1:0]      elem_data;
    logic                       elem_valid;
    logic                       elem_ready;
    logic [CW-1:0]              elem_chan;
    logic                       elem_ch_last;
    logic                       elem_last;

    modport master (
        output in_vec, in_valid, elem_ready,
        input  in_ready, elem_data, elem_valid, elem_chan, elem_ch_last, elem_last
    );

    modport slave (
        input  in_vec, in_valid, elem_ready,
        output in_ready, elem_data, elem_valid, elem_chan, elem_ch_last, elem_last
    );
endinterface

// File: rtl/bn_lane_sel.sv
// bn_lane_sel: combinational size:1 lane mux.
//   vec  - packed vector, lane i at vec[i*DATA_WIDTH +: DATA_WIDTH]
//   sel  - lane index
//   lane - selected lane, bit-exact
module bn_lane_sel #(
    parameter int DATA_WIDTH = 16,
    parameter int size       = 8,
    parameter int IW         = 3
) (
    input  logic [DATA_WIDTH*size-1:0] vec,
    input  logic [IW-1:0]              sel,
    output logic [DATA_WIDTH-1:0]      lane
);
    logic [size-1:0][DATA_WIDTH-1:0] lanes;

    assign lanes = vec;
    assign lane  = lanes[sel];
endmodule

// File: rtl/bn_vec_serializer.sv
// bn_vec_serializer: takes one packed FP16 vector per handshake and emits it
// one lane per cycle (lane 0 first), tagged with channel index and last flags.
// A two-deep buffer (act_reg being emitted, pend_reg queued) keeps vectors
// streaming back-to-back without bubbles.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - slave side of bn_vec_serializer_if (vector in, element out)
module bn_vec_serializer #(
    parameter int DATA_WIDTH = bn_pkg::DATA_WIDTH,
    parameter int size       = 8,
    parameter int channel    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    bn_vec_serializer_if.slave   bus
);
    import bn_pkg::*;

    localparam int CW  = ($clog2(channel) > 0) ? $clog2(channel) : 1;
    localparam int IW  = ($clog2(size) > 0) ? $clog2(size) : 1;
    localparam int LPC = size / channel;   // lanes per channel
    localparam int VW  = DATA_WIDTH * size;

    if (size % channel != 0) begin : g_bad_channel
        $error("bn_vec_serializer: size must be a multiple of channel");
    end

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [VW-1:0] act_q, act_d;
    logic [VW-1:0] pend_q, pend_d;

    logic          in_fire, elem_fire, elem_valid, is_last;
    logic [DATA_WIDTH-1:0] lane_data;
    int unsigned   idx_i;

    // Ready and valid come from registered state only, so there is no
    // combinational path from elem_ready to in_ready.
    assign bus.in_ready = (state_q != TWO);
    assign elem_valid   = (state_q != EMPTY);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign elem_fire    = elem_valid && bus.elem_ready;
    assign is_last      = (idx_q == IW'(size - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        pend_d  = pend_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    act_d   = bus.in_vec;
                    idx_d   = '0;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (elem_fire && is_last) begin
                    idx_d = '0;
                    if (in_fire) act_d = bus.in_vec;   // straight reload, no bubble
                    else         state_d = EMPTY;
                end else begin
                    if (elem_fire) idx_d = idx_q + IW'(1);
                    if (in_fire) begin
                        pend_d  = bus.in_vec;
                        state_d = TWO;
                    end
                end
            end
            TWO: begin
                if (elem_fire && is_last) begin
                    act_d   = pend_q;
                    idx_d   = '0;
                    state_d = ONE;
                end else if (elem_fire) begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            act_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
        end
    end

    bn_lane_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .size       (size),
        .IW         (IW)
    ) u_lane_sel (
        .vec  (act_q),
        .sel  (idx_q),
        .lane (lane_data)
    );

    // Tags are forced to 0 while idle so the bus reads all-zero out of reset.
    always_comb begin
        idx_i            = 32'(idx_q);
        bus.elem_valid   = elem_valid;
        bus.elem_data    = lane_data;
        bus.elem_last    = elem_valid && is_last;
        bus.elem_ch_last = elem_valid && ((idx_i % LPC) == LPC - 1);
        bus.elem_chan    = elem_valid ? CW'(idx_i / LPC) : '0;
    end
endmodule

// File: tb/tb_bn_vec_serializer.sv
module tb_bn_vec_serializer;
    localparam int DW = 16;
    localparam int SZ = 8;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [DW*SZ-1:0] vq [4];

    bn_vec_serializer_if #(.DATA_WIDTH(DW), .size(SZ), .CW(1)) bus0 ();
    bn_vec_serializer_if #(.DATA_WIDTH(DW), .size(SZ), .CW(1)) bus1 ();

    bn_vec_serializer #(.DATA_WIDTH(DW), .size(SZ), .channel(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    bn_vec_serializer #(.DATA_WIDTH(DW), .size(SZ), .channel(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer vq[0..nv-1] back-to-back and expect a gapless element stream.
    // Optional stall: elem_ready low for stall_len cycles at element stall_at.
    task automatic stream(input int nv, input int stall_at, input int stall_len);
        int   vi, j, st, guard;
        logic fire;
        vi = 0; j = 0; st = 0; guard = 0;
        bus0.in_vec     = vq[0];
        bus0.in_valid   = 1'b1;
        bus0.elem_ready = 1'b1;
        chk("acc_rdy", 32'(bus0.in_ready), 1);
        tick();
        vi = 1;
        bus0.in_valid = (nv > 1);
        bus0.in_vec   = vq[(nv > 1) ? 1 : 0];
        while (j < nv * SZ && guard < 300) begin
            guard++;
            bus0.elem_ready = !(j == stall_at && st < stall_len);
            chk("valid", 32'(bus0.elem_valid), 1);
            chk("data", 32'(bus0.elem_data), 32'(vq[j / SZ][(j % SZ) * DW +: DW]));
            chk("last", 32'(bus0.elem_last), 32'((j % SZ) == SZ - 1));
            if (!bus0.elem_ready) chk("stall_rdy", 32'(bus0.in_ready), 0);
            fire = bus0.in_valid && bus0.in_ready;
            tick();
            if (bus0.elem_ready) j++;
            else                 st++;
            if (fire) begin
                vi++;
                bus0.in_valid = (vi < nv);
                bus0.in_vec   = vq[(vi < nv) ? vi : 0];
            end
        end
        chk("elem_cnt", 32'(j), 32'(nv * SZ));
        chk("vec_cnt", 32'(vi), 32'(nv));
        chk("drain", 32'(bus0.elem_valid), 0);
    endtask

    initial begin
        logic [15:0] exp2 [8];
        n_vec = 0;
        n_err = 0;
        exp2 = '{16'h4500, 16'h4400, 16'h4200, 16'h4200,
                 16'h4500, 16'h4400, 16'h4200, 16'h4200};

        // 1: reset with in_valid high -> nothing accepted
        reset = 1'b1;
        bus0.in_vec = 128'h4200_4200_4400_4500_4200_4200_4400_4500;
        bus0.in_valid = 1'b1;
        bus0.elem_ready = 1'b1;
        bus1.in_vec = '0;
        bus1.in_valid = 1'b0;
        bus1.elem_ready = 1'b1;
        tick();
        chk("rst_valid", 32'(bus0.elem_valid), 0);
        tick();
        reset = 1'b0;
        bus0.in_valid = 1'b0;
        tick();
        chk("post_rst_valid", 32'(bus0.elem_valid), 0);
        chk("post_rst_ready", 32'(bus0.in_ready), 1);
        chk("post_rst_data", 32'(bus0.elem_data), 0);
        chk("post_rst_last", 32'(bus0.elem_last), 0);

        // 2: single vector, lane 0 appears the cycle after acceptance
        bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        for (int k = 0; k < SZ; k++) begin
            chk("t2_valid", 32'(bus0.elem_valid), 1);
            chk("t2_data", 32'(bus0.elem_data), 32'(exp2[k]));
            chk("t2_last", 32'(bus0.elem_last), 32'(k == SZ - 1));
            tick();
        end
        chk("t2_idle", 32'(bus0.elem_valid), 0);

        // 3: back-to-back A,B,C
        vq[0] = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
        vq[1] = 128'h7C01_0001_8000_FBFF_0217_0216_0215_0214;
        vq[2] = 128'hFFFF_3C00_0000_7E00_AAAA_5555_1234_ABCD;
        stream(3, -1, 0);

        // 4: 5-cycle stall at lane 3 of D, E queued, F held off
        vq[0] = 128'hD007_D006_D005_D004_D003_D002_D001_D000;
        vq[1] = 128'hE007_E006_E005_E004_E003_E002_E001_E000;
        vq[2] = 128'hF007_F006_F005_F004_F003_F002_F001_F000;
        stream(3, 3, 5);

        // 5: channel=2 tagging
        bus1.in_vec = {8{16'h3C00}};
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        for (int k = 0; k < SZ; k++) begin
            chk("t5_data", 32'(bus1.elem_data), 32'h3C00);
            chk("t5_chan", 32'(bus1.elem_chan), 32'(k / 4));
            chk("t5_ch_last", 32'(bus1.elem_ch_last), 32'((k % 4) == 3));
            chk("t5_last", 32'(bus1.elem_last), 32'(k == SZ - 1));
            tick();
        end
        chk("t5_idle", 32'(bus1.elem_valid), 0);

        // 6: async reset at lane 3 with pend full
        bus0.in_vec = 128'h6007_6006_6005_6004_6003_6002_6001_6000;
        bus0.in_valid = 1'b1;
        bus0.elem_ready = 1'b1;
        tick();
        bus0.in_vec = 128'h7007_7006_7005_7004_7003_7002_7001_7000;
        tick();
        bus0.in_valid = 1'b0;
        tick();
        tick();
        chk("t6_pre_data", 32'(bus0.elem_data), 32'h6003);
        chk("t6_pre_ready", 32'(bus0.in_ready), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus0.elem_valid), 0);
        chk("t6_rst_data", 32'(bus0.elem_data), 0);
        chk("t6_rst_last", 32'(bus0.elem_last), 0);
        chk("t6_rst_chlast", 32'(bus0.elem_ch_last), 0);
        chk("t6_rst_chan", 32'(bus0.elem_chan), 0);
        chk("t6_rst_ready", 32'(bus0.in_ready), 1);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_idle", 32'(bus0.elem_valid), 0);
        vq[0] = 128'h8807_8806_8805_8804_8803_8802_8801_8800;
        stream(1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
